// File: rtl/mult_pkg.sv
// Shared types for the shift-add multiplier: FSM state encoding and default operand width.
package mult_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/add_sub_n.sv
// N+1-bit adder/subtractor; operands are sign- or zero-extended by one bit before the add/sub.
module add_sub_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  input  logic         sign_ext_i,
  output logic [N:0]   sum_o
);

  logic [N:0] a_x;
  logic [N:0] b_x;

  assign a_x   = {sign_ext_i & a_i[N-1], a_i};
  assign b_x   = {sign_ext_i & b_i[N-1], b_i};
  assign sum_o = sub_i ? (a_x - b_x) : (a_x + b_x);

endmodule

// File: rtl/shift_add_mult.sv
// Sequential signed/unsigned shift-add multiplier; Done rises 2*WIDTH+2 edges after Start is taken.
// Optional Ovf output (overflow of the WIDTH-bit result range) is built when MULT_OVF_EN is defined.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               signed_mode_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o,
`ifdef MULT_OVF_EN
  output logic               ovf_o,
`endif
  output logic               xval_o
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, s_q, s_d;
  logic               x_q, x_d, mode_q, mode_d, done_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     sum;
  logic               last_iter;
`ifdef MULT_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // The multiplier MSB carries negative weight in signed mode, hence the final subtract.
  add_sub_n #(.N(WIDTH)) u_add_sub (
    .a_i       (a_q),
    .b_i       (s_q),
    .sub_i     (mode_q & last_iter),
    .sign_ext_i(mode_q),
    .sum_o     (sum)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    x_d     = x_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
`ifdef MULT_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          s_d     = op_a_i;
          b_d     = op_b_i;
          mode_d  = signed_mode_i;
        end
      end
      LOAD: begin
        a_d     = '0;
        x_d     = 1'b0;
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        if (b_q[0]) begin
          {x_d, a_d} = sum;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        x_d   = mode_q & x_q;
        a_d   = {x_q, a_q[WIDTH-1:1]};
        b_d   = {a_q[0], b_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = DONE;
          prod_d  = {a_d, b_d};
`ifdef MULT_OVF_EN
          ovf_d = mode_q ? !((&prod_d[2*WIDTH-1:WIDTH-1]) || !(|prod_d[2*WIDTH-1:WIDTH-1]))
                         : (|prod_d[2*WIDTH-1:WIDTH]);
`endif
        end else begin
          state_d = ADD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      x_q     <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
`ifdef MULT_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      // Registered from the DONE state so the pulse lands one edge after DONE is entered.
      done_q  <= (state_q == DONE);
`ifdef MULT_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_o    = (state_q == LOAD) || (state_q == ADD) || (state_q == SHIFT);
  assign done_o    = done_q;
  assign product_o = prod_q;
  assign xval_o    = x_q;
`ifdef MULT_OVF_EN
  assign ovf_o     = ovf_q;
`endif

endmodule

// File: tb/tb_shift_add_mult.sv
// Randomized bench for shift_add_mult with an arithmetic reference model and literal anchor cases.
module tb_shift_add_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           sm = 1'b0;
  logic [W-1:0]   op_a = '0;
  logic [W-1:0]   op_b = '0;
  logic           busy, done, xval;
  logic [2*W-1:0] prod;
`ifdef MULT_OVF_EN
  logic           ovf;
`endif

  int checks = 0;
  int failures = 0;

  shift_add_mult #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .signed_mode_i(sm),
    .op_a_i       (op_a),
    .op_b_i       (op_b),
    .busy_o       (busy),
    .done_o       (done),
    .product_o    (prod),
`ifdef MULT_OVF_EN
    .ovf_o        (ovf),
`endif
    .xval_o       (xval)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int ref_val(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int p;
    if (s) p = int'($signed(a)) * int'($signed(b));
    else   p = int'(a) * int'(b);
    return p;
  endfunction

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int p;
    p = ref_val(a, b, s);
    return p[2*W-1:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int p;
    p = ref_val(a, b, s);
    if (s) return (p < -(1 << (W-1))) || (p > (1 << (W-1)) - 1);
    return p > (1 << W) - 1;
  endfunction

  // Model: m_k counts edges since the accepted Start (-1 = none since reset).
  int             m_k = -1;
  logic [2*W-1:0] m_prod = '0, m_pend = '0;
  logic           m_sm = 1'b0, m_sm_pend = 1'b0;
  logic           m_ovf = 1'b0, m_ovf_pend = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_k = -1; m_prod = '0; m_sm = 1'b0; m_ovf = 1'b0;
    end else begin
      if ((m_k < 0 || m_k >= 2*W+2) && start) begin
        m_k        = 0;
        m_pend     = ref_mul(op_a, op_b, sm);
        m_sm_pend  = sm;
        m_ovf_pend = ref_ovf(op_a, op_b, sm);
      end else if (m_k >= 0 && m_k < 1000) begin
        m_k++;
      end
      if (m_k == 2*W+1) begin
        m_prod = m_pend; m_sm = m_sm_pend; m_ovf = m_ovf_pend;
      end
    end
    #1;
    chk("busy", 32'(busy), 32'(m_k >= 0 && m_k <= 2*W));
    chk("done", 32'(done), 32'(m_k == 2*W+2));
    if (m_k < 0 || m_k >= 2*W+1) begin
      chk("product", 32'(prod), 32'(m_prod));
      chk("xval", 32'(xval), 32'(m_sm & m_prod[2*W-1]));
`ifdef MULT_OVF_EN
      chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int s1, input int s2, input logic rnd,
                        output int done_edge, output int bcnt, output logic [2*W-1:0] p);
    logic got = 1'b0;
    done_edge = -1; bcnt = 0;
    op_a = a; op_b = b; sm = s; start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        done_edge = i; got = 1'b1;
        break;
      end
      start = (i+1 == s1) || (i+1 == s2) || (rnd && $urandom_range(0, 3) == 0);
      op_a  = W'($urandom);
      op_b  = W'($urandom);
      sm    = 1'($urandom);
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 32'(0), 32'(1));
    p = prod;
  endtask

  initial begin
    int e, bc, dcnt;
    logic [2*W-1:0] p;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_prod", 32'(prod), 32'(0));
    chk("rst_xval", 32'(xval), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h07, 8'hC5, 1'b1, -1, -1, 1'b0, e, bc, p);
    chk("s07xC5_prod", 32'(p), 32'h0000_FE63);
    chk("s07xC5_done_edge", 32'(e), 32'd18);
    chk("s07xC5_busy_cycles", 32'(bc), 32'd17);
`ifdef MULT_OVF_EN
    chk("s07xC5_ovf", 32'(ovf), 32'd1);
`endif
    repeat (2) @(negedge clk);

    run_op(8'hFF, 8'hFF, 1'b0, -1, -1, 1'b0, e, bc, p);
    chk("uFFxFF_prod", 32'(p), 32'h0000_FE01);
    run_op(8'hFF, 8'hFF, 1'b1, -1, -1, 1'b0, e, bc, p);
    chk("sFFxFF_prod", 32'(p), 32'h0000_0001);
    run_op(8'h80, 8'h80, 1'b1, -1, -1, 1'b0, e, bc, p);
    chk("s80x80_prod", 32'(p), 32'h0000_4000);
`ifdef MULT_OVF_EN
    chk("s80x80_ovf", 32'(ovf), 32'd1);
`endif
    run_op(8'h07, 8'hFE, 1'b1, -1, -1, 1'b0, e, bc, p);
    chk("s07xFE_prod", 32'(p), 32'h0000_FFF2);
`ifdef MULT_OVF_EN
    chk("s07xFE_ovf", 32'(ovf), 32'd0);
`endif

    // Start pulses land in a SHIFT cycle (edge 3) and in the DONE cycle (edge 18).
    run_op(8'h07, 8'hC5, 1'b1, 3, 18, 1'b0, e, bc, p);
    chk("ignored_start_done_edge", 32'(e), 32'd18);
    chk("ignored_start_prod", 32'(p), 32'h0000_FE63);
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("ignored_start_no_second_done", 32'(dcnt), 32'd0);
    chk("ignored_start_busy", 32'(busy), 32'd0);
    chk("ignored_start_hold", 32'(prod), 32'h0000_FE63);

    // Reset sampled during the third ADD cycle (edge 6).
    op_a = 8'h5A; op_b = 8'hB7; sm = 1'b1; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_prod", 32'(prod), 32'd0);
    chk("abort_xval", 32'(xval), 32'd0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if (n % 8 == 0) ra = (n % 16 == 0) ? 8'h80 : 8'h00;
      run_op(ra, rb, rs, -1, -1, 1'b1, e, bc, p);
      chk("rand_prod", 32'(p), 32'(ref_mul(ra, rb, rs)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request; sampled only in IDLE.
REQ-005 Signed_Mode  input  1  1 = two's-complement operands; 0 = unsigned.
REQ-006 Op_A  input  WIDTH  multiplicand.
REQ-007 Op_B  input  WIDTH  multiplier.
REQ-008 Busy  output  1  high while an operation is in progress.
REQ-009 Done  output  1  one-cycle completion pulse.
REQ-010 Product  output  2*WIDTH  result, laid out as {A,B}.
REQ-011 Xval  output  1  extension bit above A.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, ADD, SHIFT, DONE.
REQ-013 IDLE -> LOAD on Start=1. On that edge, Op_A, Op_B and Signed_Mode SHALL be captured into S, B and mode registers.
REQ-014 LOAD SHALL clear A, X and the iteration counter, then go to ADD.
REQ-015 ADD, signed mode: if B[0]=1, {X,A} SHALL become the WIDTH+1-bit sign-extended sum A+S.
REQ-016 ADD, signed mode, final iteration: if B[0]=1, {X,A} SHALL instead become A-S. Otherwise {X,A} SHALL hold.
REQ-017 ADD, unsigned mode: if B[0]=1, {X,A} SHALL become the zero-extended sum A+S, with X taking the carry. No subtract occurs.
REQ-018 SHIFT SHALL shift {X,A,B} right by one. X SHALL be preserved in signed mode and cleared in unsigned mode.
REQ-019 SHIFT SHALL increment the counter. After WIDTH SHIFTs the FSM SHALL go to DONE, otherwise to ADD.
REQ-020 DONE SHALL drive Done=1 for exactly one cycle, then go to IDLE.
REQ-021 Done SHALL rise exactly 2*WIDTH+2 edges after the edge that sampled Start.
REQ-022 Busy SHALL be 1 in LOAD, ADD and SHIFT, and 0 in IDLE and DONE.
REQ-023 Product SHALL hold its value from DONE until the next accepted Start's LOAD.
REQ-024 Start while not in IDLE (including DONE) SHALL be ignored, with no queuing.
REQ-025 Changes on Op_A, Op_B or Signed_Mode after capture SHALL NOT affect the result.

Reset
REQ-026 Reset=1 SHALL force IDLE and set A, B, S, X, counter, Busy, Done and Product to 0 on the next edge.
REQ-027 Reset SHALL take priority over Start and over all FSM transitions.
REQ-028 Reset mid-operation SHALL abort with no Done pulse.

Configuration
REQ-029 When MULT_OVF_EN is defined, the block SHALL add output Ovf (1 bit, reset 0), updated on entry to DONE.
REQ-030 Signed mode: Ovf SHALL be 1 iff Product is not representable as a WIDTH-bit signed value.
REQ-031 Unsigned mode: Ovf SHALL be 1 iff Product[2*WIDTH-1:WIDTH] is nonzero.
REQ-032 Ovf SHALL be held with Product.
REQ-033 When MULT_OVF_EN is undefined, the Ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 Package mult_pkg SHALL hold the FSM state enum and the WIDTH default constant.
REQ-035 One sub-module, add_sub_n, SHALL implement the parametrised WIDTH+1-bit adder/subtractor with sign/zero-extend select.
REQ-036 All other logic SHALL reside in shift_add_mult.

Verification (WIDTH=8)
REQ-037 Signed, Op_A=0x07, Op_B=0xC5 -> Product=0xFE63 (-413); Done on edge 18 after Start; Busy high for 17 cycles.
REQ-038 Unsigned 0xFF*0xFF -> 0xFE01. Signed 0xFF*0xFF -> 0x0001.
REQ-039 Signed 0x80*0x80 -> 0x4000, Ovf=1. Signed 0x07*0xFE -> 0xFFF2, Ovf=0 (MULT_OVF_EN defined).
REQ-040 Start pulsed during SHIFT and again during DONE -> both ignored; a single Done pulse; Product unchanged until the next IDLE Start.
REQ-041 Reset asserted in the 3rd ADD cycle -> next edge: Busy=0, Product=0, Xval=0; no Done within 40 cycles.
REQ-042 Op_A/Op_B changed every cycle after Start -> Product matches the operands captured at Start.
